// File: rtl/pong_motion_ctrl.sv
`timescale 1ns/1ps
// Frame-rate motion controller for VGA pong: paddle from buttons, ball bounces off wall,
// screen edges and paddle, hits/misses counted; every update lands one clk after frame_tick.
module pong_motion_ctrl #(
  parameter int BAR_V       = 4,
  parameter int BALL_V      = 2,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic [1:0] btn,
  output logic [9:0] bar_y_t,
  output logic [9:0] ball_x_l,
  output logic [9:0] ball_y_t,
  output logic [1:0] state,
  output logic [7:0] hit_cnt,
  output logic [3:0] miss_cnt,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    MISS = 2'b10
  } state_t;

  localparam logic [9:0] BAR_STEP  = 10'(BAR_V);
  localparam logic [9:0] BALL_STEP = 10'(BALL_V);
  localparam logic [9:0] BAR_MAX   = 10'd408;
  localparam logic [9:0] BAR_H     = 10'd71;
  localparam logic [9:0] BALL_SZ   = 10'd7;
  localparam logic [9:0] Y_MAX     = 10'd472;
  localparam logic [9:0] WALL_X    = 10'd36;
  localparam logic [9:0] HIT_X     = 10'd592;
  localparam logic [9:0] SCREEN_W  = 10'd640;
  localparam logic [9:0] BALL_X0   = 10'd550;
  localparam logic [9:0] BALL_Y0   = 10'd240;
  localparam logic [9:0] BAR_Y0    = 10'd204;
  localparam logic [9:0] TICK_ROW  = 10'd481;
  localparam logic [5:0] MISS_LAST = 6'(MISS_FRAMES - 1);

  state_t     state_r;
  logic [1:0] btn_meta;
  logic [1:0] btn_sync;
  logic       dx_neg;
  logic       dy_neg;
  logic [5:0] miss_frames;

  logic [9:0] bar_next;
  logic [9:0] y_next;
  logic       y_flip;
  logic [9:0] x_next;
  logic       x_flip;
  logic       paddle_hit;
  logic       ball_out;

  assign state = state_r;

  // Next-frame candidates; only committed on a frame_tick cycle.
  always_comb begin
    bar_next = bar_y_t;
    if (btn_sync == 2'b01) begin
      bar_next = (bar_y_t < BAR_STEP) ? 10'd0 : bar_y_t - BAR_STEP;
    end else if (btn_sync == 2'b10) begin
      bar_next = (bar_y_t >= BAR_MAX - BAR_STEP) ? BAR_MAX : bar_y_t + BAR_STEP;
    end
  end

  always_comb begin
    y_flip = 1'b0;
    if (dy_neg) begin
      if (ball_y_t <= BALL_STEP) begin
        y_next = 10'd0;
        y_flip = 1'b1;
      end else begin
        y_next = ball_y_t - BALL_STEP;
      end
    end else begin
      if (ball_y_t >= Y_MAX - BALL_STEP) begin
        y_next = Y_MAX;
        y_flip = 1'b1;
      end else begin
        y_next = ball_y_t + BALL_STEP;
      end
    end
  end

  // Paddle overlap is judged on the positions before this frame's update.
  assign paddle_hit = !dx_neg
                   && (ball_x_l + BALL_STEP > HIT_X)
                   && (ball_x_l <= HIT_X)
                   && (ball_y_t + BALL_SZ >= bar_y_t)
                   && (ball_y_t <= bar_y_t + BAR_H);

  always_comb begin
    x_flip = 1'b0;
    if (dx_neg) begin
      if (ball_x_l <= WALL_X + BALL_STEP) begin
        x_next = WALL_X;
        x_flip = 1'b1;
      end else begin
        x_next = ball_x_l - BALL_STEP;
      end
    end else if (paddle_hit) begin
      x_next = HIT_X;
      x_flip = 1'b1;
    end else begin
      x_next = ball_x_l + BALL_STEP;
    end
  end

  assign ball_out = !dx_neg && !paddle_hit && (x_next >= SCREEN_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      btn_meta    <= 2'b00;
      btn_sync    <= 2'b00;
      frame_tick  <= 1'b0;
      bar_y_t     <= BAR_Y0;
      ball_x_l    <= BALL_X0;
      ball_y_t    <= BALL_Y0;
      dx_neg      <= 1'b1;
      dy_neg      <= 1'b0;
      hit_cnt     <= 8'd0;
      miss_cnt    <= 4'd0;
      miss_frames <= 6'd0;
    end else begin
      btn_meta   <= btn;
      btn_sync   <= btn_meta;
      frame_tick <= pix_en && (v_count == TICK_ROW) && (h_count == 10'd0);
      if (frame_tick) begin
        bar_y_t <= bar_next;
        case (state_r)
          IDLE: begin
            if (|btn_sync) state_r <= PLAY;
          end
          PLAY: begin
            ball_y_t <= y_next;
            dy_neg   <= dy_neg ^ y_flip;
            ball_x_l <= x_next;
            dx_neg   <= dx_neg ^ x_flip;
            if (paddle_hit) hit_cnt <= hit_cnt + 8'd1;
            if (ball_out) begin
              state_r     <= MISS;
              miss_frames <= 6'd0;
              if (miss_cnt != 4'hF) miss_cnt <= miss_cnt + 4'd1;
            end
          end
          MISS: begin
            if (miss_frames == MISS_LAST) begin
              state_r  <= IDLE;
              ball_x_l <= BALL_X0;
              ball_y_t <= BALL_Y0;
              dx_neg   <= 1'b1;
              dy_neg   <= 1'b0;
            end else begin
              miss_frames <= miss_frames + 6'd1;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule
